// File: rtl/vga_timing_gen_if.sv
// Output bundle of vga_timing_gen: sync, data-enable, coordinates and strobes, plus the requested mode.
// qFRAME is present only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int CW = 12
);
    logic          MODE;
    logic          HSYNC;
    logic          VSYNC;
    logic          DE;
    logic [CW-1:0] qX;
    logic [CW-1:0] qY;
    logic          LINE_START;
    logic          FRAME_START;
    logic          MODE_ACT;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]   qFRAME;

    modport master (
        input  MODE,
        output HSYNC, VSYNC, DE, qX, qY, LINE_START, FRAME_START, MODE_ACT, qFRAME
    );
    modport slave (
        output MODE,
        input  HSYNC, VSYNC, DE, qX, qY, LINE_START, FRAME_START, MODE_ACT, qFRAME
    );
`else
    modport master (
        input  MODE,
        output HSYNC, VSYNC, DE, qX, qY, LINE_START, FRAME_START, MODE_ACT
    );
    modport slave (
        output MODE,
        input  HSYNC, VSYNC, DE, qX, qY, LINE_START, FRAME_START, MODE_ACT
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Dual-set VGA/LCD timing generator; the timing set switches only at frame boundaries.
// Optional frame counter output qFRAME enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int CW     = 12,
    parameter int A_HS   = 128,
    parameter int A_HB   = 88,
    parameter int A_HA   = 800,
    parameter int A_HF   = 40,
    parameter int A_VS   = 4,
    parameter int A_VB   = 23,
    parameter int A_VA   = 600,
    parameter int A_VF   = 1,
    parameter int B_HS   = 96,
    parameter int B_HB   = 48,
    parameter int B_HA   = 640,
    parameter int B_HF   = 16,
    parameter int B_VS   = 2,
    parameter int B_VB   = 33,
    parameter int B_VA   = 480,
    parameter int B_VF   = 10,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input logic               CLK,
    input logic               RSTn,
    vga_timing_gen_if.master  vga
);

    // One extra bit so a total equal to 2^CW still compares correctly.
    localparam int XW = CW + 1;

    localparam logic [XW-1:0] A_HS_X  = XW'(A_HS);
    localparam logic [XW-1:0] A_HBE_X = XW'(A_HS + A_HB);
    localparam logic [XW-1:0] A_HAE_X = XW'(A_HS + A_HB + A_HA);
    localparam logic [XW-1:0] A_HTM_X = XW'(A_HS + A_HB + A_HA + A_HF - 1);
    localparam logic [XW-1:0] A_VS_X  = XW'(A_VS);
    localparam logic [XW-1:0] A_VBE_X = XW'(A_VS + A_VB);
    localparam logic [XW-1:0] A_VAE_X = XW'(A_VS + A_VB + A_VA);
    localparam logic [XW-1:0] A_VTM_X = XW'(A_VS + A_VB + A_VA + A_VF - 1);

    localparam logic [XW-1:0] B_HS_X  = XW'(B_HS);
    localparam logic [XW-1:0] B_HBE_X = XW'(B_HS + B_HB);
    localparam logic [XW-1:0] B_HAE_X = XW'(B_HS + B_HB + B_HA);
    localparam logic [XW-1:0] B_HTM_X = XW'(B_HS + B_HB + B_HA + B_HF - 1);
    localparam logic [XW-1:0] B_VS_X  = XW'(B_VS);
    localparam logic [XW-1:0] B_VBE_X = XW'(B_VS + B_VB);
    localparam logic [XW-1:0] B_VAE_X = XW'(B_VS + B_VB + B_VA);
    localparam logic [XW-1:0] B_VTM_X = XW'(B_VS + B_VB + B_VA + B_VF - 1);

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          mode_act;

    logic [XW-1:0] hs_x, hbe_x, hae_x, htm_x;
    logic [XW-1:0] vs_x, vbe_x, vae_x, vtm_x;
    logic [XW-1:0] hc_x, vc_x;
    logic          h_end, v_end, de_next;
    logic [CW-1:0] qx_next, qy_next;

    logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
    logic [CW-1:0] qx_q, qy_q;

    always_comb begin
        hs_x  = A_HS_X;
        hbe_x = A_HBE_X;
        hae_x = A_HAE_X;
        htm_x = A_HTM_X;
        vs_x  = A_VS_X;
        vbe_x = A_VBE_X;
        vae_x = A_VAE_X;
        vtm_x = A_VTM_X;
        if (mode_act) begin
            hs_x  = B_HS_X;
            hbe_x = B_HBE_X;
            hae_x = B_HAE_X;
            htm_x = B_HTM_X;
            vs_x  = B_VS_X;
            vbe_x = B_VBE_X;
            vae_x = B_VAE_X;
            vtm_x = B_VTM_X;
        end
    end

    assign hc_x    = {1'b0, hc};
    assign vc_x    = {1'b0, vc};
    assign h_end   = (hc_x == htm_x);
    assign v_end   = (vc_x == vtm_x);
    assign de_next = (hc_x >= hbe_x) && (hc_x < hae_x) && (vc_x >= vbe_x) && (vc_x < vae_x);
    assign qx_next = hc - hbe_x[CW-1:0];
    assign qy_next = vc - vbe_x[CW-1:0];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            hc            <= '0;
            vc            <= '0;
            mode_act      <= 1'b0;
            hsync_q       <= !HS_POL;
            vsync_q       <= !VS_POL;
            de_q          <= 1'b0;
            qx_q          <= '0;
            qy_q          <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q <= (hc_x < hs_x) ? HS_POL : !HS_POL;
            if (hc == '0) begin
                vsync_q <= (vc_x < vs_x) ? VS_POL : !VS_POL;
            end
            de_q          <= de_next;
            qx_q          <= de_next ? qx_next : '0;
            qy_q          <= de_next ? qy_next : '0;
            line_start_q  <= (hc == '0);
            frame_start_q <= (hc == '0) && (vc == '0);

            // The requested set is latched only on the last clock of a frame.
            if (h_end) begin
                hc <= '0;
                if (v_end) begin
                    vc       <= '0;
                    mode_act <= vga.MODE;
                end else begin
                    vc <= vc + 1'b1;
                end
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    assign vga.HSYNC       = hsync_q;
    assign vga.VSYNC       = vsync_q;
    assign vga.DE          = de_q;
    assign vga.qX          = qx_q;
    assign vga.qY          = qy_q;
    assign vga.LINE_START  = line_start_q;
    assign vga.FRAME_START = frame_start_q;
    assign vga.MODE_ACT    = mode_act;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    // Steps at the end of the FRAME_START cycle, so the pulse carries the index of its frame.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            frame_cnt <= '0;
        end else if (frame_start_q) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign vga.qFRAME = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with small timing sets: frame-position reference model plus directed literal checks.
module tb_vga_timing_gen;

    localparam int CW = 4;
    localparam int A_HS = 3, A_HB = 2, A_HA = 8,  A_HF = 2;
    localparam int A_VS = 2, A_VB = 2, A_VA = 5,  A_VF = 1;
    localparam int B_HS = 2, B_HB = 3, B_HA = 10, B_HF = 1;
    localparam int B_VS = 1, B_VB = 2, B_VA = 4,  B_VF = 2;
    localparam bit HS_POL = 1'b1;
    localparam bit VS_POL = 1'b0;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    logic mode = 1'b0;

    int checks   = 0;
    int failures = 0;

    vga_timing_gen_if #(.CW(CW)) vif();
    assign vif.MODE = mode;

    vga_timing_gen #(
        .CW(CW),
        .A_HS(A_HS), .A_HB(A_HB), .A_HA(A_HA), .A_HF(A_HF),
        .A_VS(A_VS), .A_VB(A_VB), .A_VA(A_VA), .A_VF(A_VF),
        .B_HS(B_HS), .B_HB(B_HB), .B_HA(B_HA), .B_HF(B_HF),
        .B_VS(B_VS), .B_VB(B_VB), .B_VA(B_VA), .B_VF(B_VF),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .vga (vif)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position p within the frame, decoded with plain division/modulo.
    int   m_p, m_mode;
    int   hT, vT, hS, hBE, hAE, vS, vBE, vAE, hcv, vcv;
    logic e_hs, e_vs, e_de, e_ls, e_fs, e_ma;
    int   e_qx, e_qy, e_qf;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_p = 0; m_mode = 0;
            e_hs = !HS_POL; e_vs = !VS_POL; e_de = 1'b0;
            e_qx = 0; e_qy = 0; e_ls = 1'b0; e_fs = 1'b0; e_ma = 1'b0; e_qf = 0;
        end else begin
            if (m_mode == 0) begin
                hS = A_HS; hBE = A_HS + A_HB; hAE = A_HS + A_HB + A_HA; hT = hAE + A_HF;
                vS = A_VS; vBE = A_VS + A_VB; vAE = A_VS + A_VB + A_VA; vT = vAE + A_VF;
            end else begin
                hS = B_HS; hBE = B_HS + B_HB; hAE = B_HS + B_HB + B_HA; hT = hAE + B_HF;
                vS = B_VS; vBE = B_VS + B_VB; vAE = B_VS + B_VB + B_VA; vT = vAE + B_VF;
            end
            hcv = m_p % hT;
            vcv = m_p / hT;
            if (e_fs) e_qf = (e_qf + 1) % 65536;
            e_hs = (hcv < hS) ? HS_POL : !HS_POL;
            e_vs = (vcv < vS) ? VS_POL : !VS_POL;
            e_de = (hcv >= hBE) && (hcv < hAE) && (vcv >= vBE) && (vcv < vAE);
            e_qx = e_de ? hcv - hBE : 0;
            e_qy = e_de ? vcv - vBE : 0;
            e_ls = (hcv == 0);
            e_fs = (m_p == 0);
            if (m_p == hT * vT - 1) begin
                m_p    = 0;
                m_mode = (mode === 1'b1) ? 1 : 0;
            end else begin
                m_p++;
            end
            e_ma = (m_mode != 0);
        end
    end

    always @(negedge CLK) begin
        chk("hsync",       vif.HSYNC,       e_hs);
        chk("vsync",       vif.VSYNC,       e_vs);
        chk("de",          vif.DE,          e_de);
        chk("qx",          vif.qX,          e_qx);
        chk("qy",          vif.qY,          e_qy);
        chk("line_start",  vif.LINE_START,  e_ls);
        chk("frame_start", vif.FRAME_START, e_fs);
        chk("mode_act",    vif.MODE_ACT,    e_ma);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("qframe",      vif.qFRAME,      e_qf);
`endif
    end

    // Count negedges until the selected pulse is seen (0=FRAME_START, 1=LINE_START, 2=DE).
    task automatic wait_sig(input int sel, output int n);
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 2000) begin
            @(negedge CLK);
            n++;
            case (sel)
                0:       hit = (vif.FRAME_START === 1'b1);
                1:       hit = (vif.LINE_START === 1'b1);
                default: hit = (vif.DE === 1'b1);
            endcase
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL wait_sig%0d: no pulse after %0d cycles", sel, n);
        end
    endtask

    int n, cnt, len, last_qx, first_qx;

    initial begin
        mode = 1'b0;
        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_hsync",  vif.HSYNC, 0);
        chk("rst_vsync",  vif.VSYNC, 1);
        chk("rst_de",     vif.DE, 0);
        chk("rst_fs",     vif.FRAME_START, 0);
        chk("rst_ls",     vif.LINE_START, 0);
        chk("rst_modeact",vif.MODE_ACT, 0);
        RSTn = 1'b1;

        @(posedge CLK); #1;
        chk("first_hsync", vif.HSYNC, 1);
        chk("first_vsync", vif.VSYNC, 0);
        chk("first_fs",    vif.FRAME_START, 1);
        chk("first_ls",    vif.LINE_START, 1);
        chk("first_de",    vif.DE, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("first_qframe", vif.qFRAME, 0);
`endif
        @(negedge CLK);

        // Set A: 15 clocks/line, 10 lines/frame, first DE at line 4 column 5.
        wait_sig(2, n);  chk("a_first_de_offset", n, 65);
        wait_sig(0, n);  chk("a_de_to_frame_end", n, 85);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("qframe_1", vif.qFRAME, 1);
`endif
        wait_sig(1, n);  chk("a_line_period", n, 15);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (vif.HSYNC === HS_POL) cnt++;
            @(negedge CLK);
        end
        chk("a_hsync_width", cnt, 3);
        wait_sig(2, n);  chk("a_de_offset_line2", n, 35);
        first_qx = int'(vif.qX);
        len = 0; last_qx = 0;
        while (vif.DE === 1'b1 && len < 100) begin
            last_qx = int'(vif.qX);
            len++;
            @(negedge CLK);
        end
        chk("a_de_run", len, 8);
        chk("a_qx_first", first_qx, 0);
        chk("a_qx_last", last_qx, 7);

        // Mid-frame mode request: no effect until the frame ends.
        mode = 1'b1;
        repeat (5) @(negedge CLK);
        chk("mode_act_hold", vif.MODE_ACT, 0);
        wait_sig(0, n);
        chk("mode_act_switch", vif.MODE_ACT, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("qframe_2", vif.qFRAME, 2);
`endif
        wait_sig(0, n);  chk("b_frame_period", n, 144);
        wait_sig(1, n);  chk("b_line_period", n, 16);

        // Glitch 1->0->1 inside a set-B frame.
        repeat (20) @(negedge CLK);
        mode = 1'b0;
        repeat (5) @(negedge CLK);
        mode = 1'b1;
        wait_sig(0, n);
        chk("glitch_keeps_b", vif.MODE_ACT, 1);

        // Randomised mode requests; the model checks every cycle.
        repeat (9000) begin
            @(negedge CLK);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
        end

        // Asynchronous reset during active video.
        wait_sig(2, n);
        mode = 1'b1;
        @(posedge CLK); #2;
        RSTn = 1'b0;
        #1;
        chk("async_hsync", vif.HSYNC, 0);
        chk("async_vsync", vif.VSYNC, 1);
        chk("async_de",    vif.DE, 0);
        chk("async_qx",    vif.qX, 0);
        chk("async_qy",    vif.qY, 0);
        chk("async_ls",    vif.LINE_START, 0);
        chk("async_fs",    vif.FRAME_START, 0);
        chk("async_modeact", vif.MODE_ACT, 0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK); #1;
        chk("rerelease_fs", vif.FRAME_START, 1);
        chk("rerelease_modeact", vif.MODE_ACT, 0);
        @(negedge CLK);
        wait_sig(0, n);  chk("rerelease_a_period", n, 150);
        chk("rerelease_switch_b", vif.MODE_ACT, 1);

        repeat (3000) begin
            @(negedge CLK);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
